// File: rtl/clock_divider_pkg.sv
// Shared constants for the programmable clock divider: output-mode encoding
// and the default divisor width and reset divisor.
package clock_divider_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV   = 3;

    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_SQUARE = 1'b1
    } mode_e;

endpackage

// File: rtl/clock_divider_if.sv
// Control and status bundle of the clock divider; the master drives enable,
// mode and divisor loads, the slave (the divider) returns the divided outputs.
interface clock_divider_if #(
    parameter int WIDTH = clock_divider_pkg::DEF_WIDTH
);

    logic             en;
    logic             mode;
    logic             div_load;
    logic [WIDTH-1:0] div_value;
    logic             tick;
    logic             clk_out;
    logic             div_pending;

    modport master (
        output en, mode, div_load, div_value,
        input  tick, clk_out, div_pending
    );

    modport slave (
        input  en, mode, div_load, div_value,
        output tick, clk_out, div_pending
    );

endinterface

// File: rtl/clock_divider_shadow.sv
// Divisor shadow register: captures requested divisors (0 clamped to 1) and
// commits them to the active divisor only on a period boundary.
module clock_divider_shadow #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    output logic [WIDTH-1:0] div_active,
    output logic             div_pending
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] load_value;

    // A divisor of 0 has no meaningful period, so it behaves as divide-by-1.
    assign load_value = (div_value == '0) ? WIDTH'(1) : div_value;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_active  <= RESET_DIV;
            shadow      <= RESET_DIV;
            div_pending <= 1'b0;
        end else if (commit) begin
            // A load arriving on the boundary edge bypasses the shadow.
            div_active  <= div_load ? load_value : shadow;
            shadow      <= div_load ? load_value : shadow;
            div_pending <= 1'b0;
        end else if (div_load) begin
            shadow      <= load_value;
            div_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/clock_divider.sv
// Programmable clock divider: phase counter over the active divisor, producing
// a one-cycle tick per period and a pulse- or square-shaped divided clock.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic           clk,
    input  logic           reset,
    clock_divider_if.slave bus
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] div_active;
    logic [WIDTH:0]   half;
    logic             at_end;
    logic             boundary;

    assign at_end   = (cnt == div_active - WIDTH'(1));
    assign boundary = bus.en && at_end;
    assign cnt_next = at_end ? '0 : cnt + WIDTH'(1);

    // High phase length ceil(D/2); the extra bit keeps D+1 from wrapping at D=2^WIDTH-1.
    assign half = ({1'b0, div_active} + (WIDTH+1)'(1)) >> 1;

    clock_divider_shadow #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .commit      (boundary),
        .div_load    (bus.div_load),
        .div_value   (bus.div_value),
        .div_active  (div_active),
        .div_pending (bus.div_pending)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            bus.tick    <= 1'b0;
            bus.clk_out <= 1'b0;
        end else if (bus.en) begin
            cnt      <= cnt_next;
            bus.tick <= at_end;
            if (mode_e'(bus.mode) == MODE_SQUARE) begin
                bus.clk_out <= ({1'b0, cnt_next} < half);
            end else begin
                bus.clk_out <= at_end;
            end
        end else begin
            // Frozen: phase and divided clock hold, only the strobe drops.
            bus.tick <= 1'b0;
        end
    end

endmodule
